// File: rtl/selector_parametros_pkg.sv
// selector_parametros shared definitions
// widths, saturation defaults and repeat FSM states
package selector_parametros_pkg;

  localparam int F_W       = 3;
  localparam int C_W       = 4;
  localparam int F_MAX_DEF = 7;
  localparam int C_MAX_DEF = 15;

  localparam int N_BTN  = 2;
  localparam int BTN_UP = 0;
  localparam int BTN_DN = 1;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_HELD   = 2'd1,
    ST_REPEAT = 2'd2
  } rep_state_e;

  function automatic int cnt_w(input int n);
    return (n < 2) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/selector_parametros_antirrebote.sv
// antirrebote: 2-flop synchronizer plus debouncer
// level moves only after DEB_CYCLES consecutive mismatches
module antirrebote
  import selector_parametros_pkg::*;
#(
  parameter int DEB_CYCLES = 500000
) (
  input  logic clock,
  input  logic reset,
  input  logic btn_i,
  output logic level_o
);

  localparam int CW = cnt_w(DEB_CYCLES);

  logic          s1_q, s2_q;
  logic          lvl_q, lvl_d;
  logic [CW-1:0] cnt_q, cnt_d;

  // synchronizer chain and debounce state
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      s1_q  <= 1'b0;
      s2_q  <= 1'b0;
      lvl_q <= 1'b0;
      cnt_q <= '0;
    end else begin
      s1_q  <= btn_i;
      s2_q  <= s1_q;
      lvl_q <= lvl_d;
      cnt_q <= cnt_d;
    end
  end

  // count mismatch run; any agreeing cycle restarts it
  always_comb begin
    lvl_d = lvl_q;
    cnt_d = '0;
    if (s2_q != lvl_q) begin
      if (cnt_q == CW'(DEB_CYCLES - 1)) begin
        lvl_d = s2_q;
      end else begin
        cnt_d = cnt_q + 1'b1;
      end
    end
  end

  assign level_o = lvl_q;

endmodule

// File: rtl/selector_parametros.sv
// selector_parametros: button-driven iF/iC editor
// debounce, hold/auto-repeat, saturating update
module selector_parametros
  import selector_parametros_pkg::*;
#(
  parameter int DEB_CYCLES = 500000,
  parameter int REP_DELAY  = 25000000,
  parameter int REP_PERIOD = 10000000,
  parameter int F_MAX      = F_MAX_DEF,
  parameter int C_MAX      = C_MAX_DEF
) (
  input  logic           clock,
  input  logic           reset,
  input  logic           btn_up,
  input  logic           btn_down,
  input  logic           switch,
  output logic [F_W-1:0] iF,
  output logic [C_W-1:0] iC,
  output logic           cambio
);

  localparam int REP_MAX =
    (REP_DELAY > REP_PERIOD) ? REP_DELAY : REP_PERIOD;
  localparam int RW = cnt_w(REP_MAX);

  logic [N_BTN-1:0] btn_raw;
  logic [N_BTN-1:0] lvl;
  logic [N_BTN-1:0] step_d, step_q;

  logic sw_s1_q, sw_s2_q;

  logic [F_W-1:0] if_q, if_d;
  logic [C_W-1:0] ic_q, ic_d;
  logic           cambio_q, cambio_d;

  assign btn_raw[BTN_UP] = btn_up;
  assign btn_raw[BTN_DN] = btn_down;

  for (genvar b = 0; b < N_BTN; b++) begin : g_btn

    rep_state_e    st_q, st_d;
    logic [RW-1:0] cnt_q, cnt_d;
    logic          step;

    antirrebote #(
      .DEB_CYCLES(DEB_CYCLES)
    ) u_deb (
      .clock  (clock),
      .reset  (reset),
      .btn_i  (btn_raw[b]),
      .level_o(lvl[b])
    );

    // repeat FSM state and hold counter
    always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
        st_q  <= ST_IDLE;
        cnt_q <= '0;
      end else begin
        st_q  <= st_d;
        cnt_q <= cnt_d;
      end
    end

    // press, hold delay, then periodic steps
    always_comb begin
      st_d  = st_q;
      cnt_d = cnt_q;
      step  = 1'b0;
      unique case (st_q)
        ST_IDLE: begin
          if (lvl[b]) begin
            st_d  = ST_HELD;
            cnt_d = '0;
            step  = 1'b1;
          end
        end
        ST_HELD: begin
          if (!lvl[b]) begin
            st_d  = ST_IDLE;
            cnt_d = '0;
          end else if (cnt_q == RW'(REP_DELAY - 1)) begin
            st_d  = ST_REPEAT;
            cnt_d = '0;
            step  = 1'b1;
          end else begin
            cnt_d = cnt_q + 1'b1;
          end
        end
        ST_REPEAT: begin
          if (!lvl[b]) begin
            st_d  = ST_IDLE;
            cnt_d = '0;
          end else if (cnt_q == RW'(REP_PERIOD - 1)) begin
            cnt_d = '0;
            step  = 1'b1;
          end else begin
            cnt_d = cnt_q + 1'b1;
          end
        end
        default: begin
          st_d  = ST_IDLE;
          cnt_d = '0;
        end
      endcase
    end

    assign step_d[b] = step;

  end

  // step pipeline, switch synchronizer, outputs
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      step_q   <= '0;
      sw_s1_q  <= 1'b0;
      sw_s2_q  <= 1'b0;
      if_q     <= '0;
      ic_q     <= '0;
      cambio_q <= 1'b0;
    end else begin
      step_q   <= step_d;
      sw_s1_q  <= switch;
      sw_s2_q  <= sw_s1_q;
      if_q     <= if_d;
      ic_q     <= ic_d;
      cambio_q <= cambio_d;
    end
  end

  // saturating update of the selected register
  always_comb begin
    if_d     = if_q;
    ic_d     = ic_q;
    cambio_d = 1'b0;
    if (step_q[BTN_UP] ^ step_q[BTN_DN]) begin
      if (!sw_s2_q) begin
        if (step_q[BTN_UP]) begin
          if (if_q < F_W'(F_MAX)) begin
            if_d     = if_q + 1'b1;
            cambio_d = 1'b1;
          end
        end else if (if_q != '0) begin
          if_d     = if_q - 1'b1;
          cambio_d = 1'b1;
        end
      end else begin
        if (step_q[BTN_UP]) begin
          if (ic_q < C_W'(C_MAX)) begin
            ic_d     = ic_q + 1'b1;
            cambio_d = 1'b1;
          end
        end else if (ic_q != '0) begin
          ic_d     = ic_q - 1'b1;
          cambio_d = 1'b1;
        end
      end
    end
  end

  assign iF     = if_q;
  assign iC     = ic_q;
  assign cambio = cambio_q;

endmodule
